muldiv_hilo_ctrl: RTL and testbench

Owns the architectural HI/LO register pair and sequences every HI/LO-writing instruction issued from EX: MULT/MULTU, DIV/DIVU, MTHI/MTLO.
- Multiply results come combinationally from the external multiplier and commit in one cycle.
- Divides drive the external radix-2 divider over its opn_valid / res_ready / res_valid handshake and hold EX stalled until the result commits.
- Flush, exception and watchdog timeout cancel an in-flight divide without touching HI/LO.

---
 rtl/muldiv_hilo_ctrl.sv | 151 +++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO register owner: commits multiplies and MTHI/MTLO, sequences the external
// radix-2 divider with cancel on flush/exception and a watchdog timeout.
module muldiv_hilo_ctrl #(
  parameter int unsigned MAX_DIV_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        except,
  input  logic        stall_mem,
  input  logic [63:0] mul_result,
  output logic        mul_sign,
  output logic        div_opn_valid,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_res_ready,
  input  logic        div_res_valid,
  input  logic [63:0] div_result,
  output logic        div_cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_req,
  output logic        div_timeout
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_DIV_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              timeout_q, timeout_d;

  logic kill;
  logic is_div;
  logic write_ok;

  assign kill     = flush | except;
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign write_ok = op_valid & ~kill & ~stall_mem;

  // State and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, HI/LO write selection and divider handshake
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    timeout_d     = timeout_q;
    mul_sign      = 1'b0;
    div_opn_valid = 1'b0;
    div_sign      = 1'b0;
    div_a         = '0;
    div_b         = '0;
    div_res_ready = 1'b0;
    div_cancel    = 1'b0;
    stall_req     = 1'b0;

    if (rst) begin
      div_cancel = 1'b1;
    end else begin
      mul_sign = op_valid & (op == OP_MULT);
      unique case (state_q)
        S_IDLE: begin
          if (op_valid && !kill && is_div) begin
            div_opn_valid = 1'b1;
            div_a         = rs_val;
            div_b         = rt_val;
            div_sign      = (op == OP_DIV);
            stall_req     = 1'b1;
            state_d       = S_DIV_BUSY;
            cnt_d         = '0;
          end else if (write_ok) begin
            unique case (op)
              OP_MULT, OP_MULTU: begin
                hi_d = mul_result[63:32];
                lo_d = mul_result[31:0];
              end
              OP_MTHI: hi_d = rs_val;
              OP_MTLO: lo_d = rs_val;
              default: ;
            endcase
          end
        end
        S_DIV_BUSY: begin
          div_opn_valid = 1'b1;
          div_a         = rs_val;
          div_b         = rt_val;
          div_sign      = (op == OP_DIV);
          stall_req     = ~div_res_valid;
          cnt_d         = cnt_q + CNT_W'(1);
          // Cancel outranks a same-cycle commit
          if (kill) begin
            div_cancel = 1'b1;
            state_d    = S_IDLE;
          end else if (div_res_valid && !stall_mem) begin
            div_res_ready = 1'b1;
            hi_d          = div_result[63:32];
            lo_d          = div_result[31:0];
            state_d       = S_IDLE;
          end else if (!div_res_valid && (cnt_q == CNT_LAST)) begin
            div_cancel = 1'b1;
            timeout_d  = 1'b1;
            stall_req  = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_timeout = timeout_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: an abstract HI/LO + divide-in-flight model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_muldiv_hilo_ctrl;

  localparam int MAXC = 40;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        flush, except, stall_mem;
  logic [63:0] mul_result;
  logic        mul_sign, div_opn_valid, div_sign;
  logic [31:0] div_a, div_b;
  logic        div_res_ready, div_res_valid;
  logic [63:0] div_result;
  logic        div_cancel;
  logic [31:0] hi, lo;
  logic        stall_req, div_timeout;

  int vecs = 0;
  int errs = 0;

  muldiv_hilo_ctrl #(.MAX_DIV_CYCLES(MAXC), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .except(except),
    .stall_mem(stall_mem), .mul_result(mul_result), .mul_sign(mul_sign),
    .div_opn_valid(div_opn_valid), .div_sign(div_sign), .div_a(div_a),
    .div_b(div_b), .div_res_ready(div_res_ready), .div_res_valid(div_res_valid),
    .div_result(div_result), .div_cancel(div_cancel), .hi(hi), .lo(lo),
    .stall_req(stall_req), .div_timeout(div_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Abstract model: architectural HI/LO, whether a divide is outstanding and for how long
  logic [31:0] m_hi, m_lo;
  bit          m_busy, m_to, m_known;
  int          m_n;

  initial begin
    m_known = 0; m_busy = 0; m_to = 0; m_n = 0; m_hi = '0; m_lo = '0;
  end

  always @(negedge clk) begin : cmp
    bit kill, isdiv, start, tmo, commit;
    kill   = flush || except;
    isdiv  = (op == 3'd3) || (op == 3'd4);
    start  = !m_busy && op_valid && !kill && isdiv;
    tmo    = m_busy && !kill && !div_res_valid && (m_n == MAXC - 1);
    commit = m_busy && !kill && div_res_valid && !stall_mem;

    chk("opn_valid", 64'(div_opn_valid), 64'(!rst && (start || m_busy)));
    chk("stall_req", 64'(stall_req),
        64'(!rst && (start || (m_busy && !div_res_valid && !tmo))));
    chk("res_ready", 64'(div_res_ready), 64'(!rst && commit));
    chk("cancel", 64'(div_cancel), 64'(rst || (m_busy && (kill || tmo))));
    chk("mul_sign", 64'(mul_sign), 64'(!rst && op_valid && op == 3'd1));
    if (!rst && (start || m_busy)) begin
      chk("div_a", 64'(div_a), 64'(rs_val));
      chk("div_b", 64'(div_b), 64'(rt_val));
      chk("div_sign", 64'(div_sign), 64'(op == 3'd3));
    end
    if (m_known) begin
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("timeout", 64'(div_timeout), 64'(m_to));
    end

    // Effect of the coming clock edge
    if (rst) begin
      m_known = 1; m_hi = '0; m_lo = '0; m_busy = 0; m_to = 0; m_n = 0;
    end else if (m_busy) begin
      if (commit) begin
        m_hi = div_result[63:32];
        m_lo = div_result[31:0];
      end
      if (tmo) m_to = 1;
      if (kill || commit || tmo) m_busy = 0;
      m_n++;
    end else if (start) begin
      m_busy = 1;
      m_n = 0;
    end else if (op_valid && !kill && !stall_mem) begin
      case (op)
        3'd1, 3'd2: begin m_hi = mul_result[63:32]; m_lo = mul_result[31:0]; end
        3'd5: m_hi = rs_val;
        3'd6: m_lo = rs_val;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op_valid = 0; op = 3'd0; flush = 0; except = 0; stall_mem = 0;
    div_res_valid = 0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1; op = o; rs_val = a; rt_val = b;
  endtask

  int  stalls, readies;
  bit  done, got_cancel;

  initial begin
    rst = 1; rs_val = '0; rt_val = '0; mul_result = '0; div_result = '0;
    idle();
    repeat (2) tick();
    rst = 0;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_to", 64'(div_timeout), 64'h0);

    // MULT -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    mul_result = 64'hFFFF_FFFF_FFFF_FFFA;
    tick();
    idle();
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    // DIVU 100/7 with result 34 cycles after issue
    issue(3'd4, 32'd100, 32'd7);
    div_result = {32'd2, 32'd14};
    stalls = 0; readies = 0;
    for (int i = 0; i <= 34; i++) begin
      div_res_valid = (i == 34);
      #1;
      stalls  += int'(stall_req);
      readies += int'(div_res_ready);
      tick();
    end
    idle();
    chk("divu_stalls", 64'(stalls), 64'd34);
    chk("divu_ready_pulses", 64'(readies), 64'd1);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_lo", 64'(lo), 64'd14);

    // Preload, then DIV whose result is held off by stall_mem for 3 cycles
    issue(3'd5, 32'h11, 32'd0); tick();
    issue(3'd6, 32'h22, 32'd0); tick();
    issue(3'd3, 32'hFFFF_FFEC, 32'd3);
    div_result = {32'h33, 32'h44};
    repeat (4) tick();
    div_res_valid = 1; stall_mem = 1; readies = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      readies += int'(div_res_ready);
      tick();
    end
    chk("hold_ready", 64'(readies), 64'd0);
    chk("hold_hi", 64'(hi), 64'h11);
    chk("hold_lo", 64'(lo), 64'h22);
    stall_mem = 0;
    #1;
    chk("hold_commit_ready", 64'(div_res_ready), 64'd1);
    tick();
    div_res_valid = 0;
    #1;
    chk("b2b_restart", 64'(div_opn_valid), 64'd1);
    tick();
    flush = 1;
    tick();
    idle();
    chk("hold_commit_hi", 64'(hi), 64'h33);
    chk("hold_commit_lo", 64'(lo), 64'h44);

    // Exception in the cycle res_valid rises
    issue(3'd5, 32'h11, 32'd0); tick();
    issue(3'd6, 32'h22, 32'd0); tick();
    issue(3'd3, 32'd50, 32'd5);
    div_result = {32'h0, 32'd10};
    repeat (5) tick();
    div_res_valid = 1; except = 1;
    #1;
    chk("exc_cancel", 64'(div_cancel), 64'd1);
    chk("exc_no_ready", 64'(div_res_ready), 64'd0);
    tick();
    idle();
    tick();
    issue(3'd6, 32'd5, 32'd0); tick();
    idle();
    chk("exc_hi", 64'(hi), 64'h11);
    chk("exc_lo", 64'(lo), 64'd5);

    // Watchdog: divider never answers
    issue(3'd3, 32'd9, 32'd0);
    stalls = 0; done = 0; got_cancel = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (stall_req) stalls++;
      else begin
        done = 1;
        got_cancel = div_cancel;
      end
      tick();
    end
    idle();
    chk("wd_reached", 64'(done), 64'd1);
    chk("wd_stall_cycles", 64'(stalls), 64'd40);
    chk("wd_cancel", 64'(got_cancel), 64'd1);
    chk("wd_flag", 64'(div_timeout), 64'd1);

    // MTHI blocked by exception, then delayed by stall_mem
    issue(3'd5, 32'hABCD, 32'd0); except = 1; tick();
    except = 0;
    chk("mthi_exc_hi", 64'(hi), 64'h11);
    stall_mem = 1; tick(); tick();
    chk("mthi_stall_hi", 64'(hi), 64'h11);
    stall_mem = 0; tick();
    idle(); tick();
    chk("mthi_hi", 64'(hi), 64'hABCD);
    chk("wd_sticky", 64'(div_timeout), 64'd1);

    // Reset in the middle of a divide
    issue(3'd4, 32'd77, 32'd4);
    tick(); tick();
    rst = 1;
    #1;
    chk("rst_mid_cancel", 64'(div_cancel), 64'd1);
    tick();
    rst = 0; idle(); tick();
    chk("rst_mid_hi", 64'(hi), 64'h0);
    chk("rst_mid_lo", 64'(lo), 64'h0);
    chk("rst_mid_to", 64'(div_timeout), 64'h0);
    chk("rst_mid_stall", 64'(stall_req), 64'h0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
